// File: rtl/eq_coeff_scheduler.sv
// Coefficient reload sequencer for the equalizer band filters: queues per-band
// preset requests, serves them round-robin and streams ROM taps into each filter.
module eq_coeff_scheduler #(
  parameter int NUM_BANDS = 8,
  parameter int TAPS      = 64,
  parameter int COEF_W    = 16,
  parameter int PRESET_W  = 4,
  localparam int BAND_W   = $clog2(NUM_BANDS),
  localparam int TAP_W    = $clog2(TAPS),
  localparam int ADDR_W   = PRESET_W + TAP_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable,
  input  logic                     req_valid,
  input  logic [BAND_W-1:0]        req_band,
  input  logic [PRESET_W-1:0]      req_preset,
  output logic                     rom_rd_en,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic signed [COEF_W-1:0] rom_data,
  output logic [NUM_BANDS-1:0]     write_enable,
  output logic [NUM_BANDS-1:0]     write_done,
  output logic [TAP_W-1:0]         write_address,
  output logic signed [COEF_W-1:0] coeffs_out,
  output logic                     busy,
  output logic                     band_loaded,
  output logic [BAND_W-1:0]        loaded_band
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                             state, state_nxt;
  logic [TAP_W-1:0]                   tap, tap_nxt;
  logic [NUM_BANDS-1:0]               pending, pending_nxt;
  logic [NUM_BANDS-1:0][PRESET_W-1:0] preset_q;
  logic [BAND_W-1:0]                  rr_ptr;
  logic [BAND_W-1:0]                  cur_band;
  logic [PRESET_W-1:0]                cur_preset;
  logic                               grant;
  logic                               found;
  logic [BAND_W-1:0]                  grant_band;
  logic [BAND_W-1:0]                  idx;
  logic [PRESET_W-1:0]                preset_sel;
  logic                               load_close;

  // Round-robin search: first pending band at or after rr_ptr, wrapping.
  always_comb begin
    found      = 1'b0;
    grant_band = '0;
    idx        = '0;
    for (int i = 0; i < NUM_BANDS; i++) begin
      idx = rr_ptr + BAND_W'(i);
      if (!found && pending[idx]) begin
        found      = 1'b1;
        grant_band = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tap_nxt   = tap;
    grant     = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) begin
          grant     = 1'b1;
          tap_nxt   = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_WRITE;
      S_WRITE: begin
        if (clk_enable) begin
          if (tap == TAP_W'(TAPS - 1)) begin
            state_nxt = S_DONE;
          end else begin
            tap_nxt   = tap + TAP_W'(1);
            state_nxt = S_FETCH;
          end
        end
      end
      S_DONE: begin
        if (clk_enable) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A request landing in the grant cycle for the granted band re-arms it.
  always_comb begin
    pending_nxt = pending;
    if (grant) pending_nxt[grant_band] = 1'b0;
    if (req_valid) pending_nxt[req_band] = 1'b1;
  end

  assign preset_sel = grant ? preset_q[grant_band] : cur_preset;
  assign load_close = (state == S_DONE) && clk_enable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      tap   <= '0;
    end else begin
      state <= state_nxt;
      tap   <= tap_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= '0;
      preset_q   <= '0;
      rr_ptr     <= '0;
      cur_band   <= '0;
      cur_preset <= '0;
    end else begin
      pending <= pending_nxt;
      if (req_valid) preset_q[req_band] <= req_preset;
      if (grant) begin
        cur_band   <= grant_band;
        cur_preset <= preset_q[grant_band];
        rr_ptr     <= grant_band + BAND_W'(1);
      end
    end
  end

  // Outputs are registered from the next state so strobes align with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_rd_en     <= 1'b0;
      rom_addr      <= '0;
      write_enable  <= '0;
      write_done    <= '0;
      write_address <= '0;
      coeffs_out    <= '0;
      busy          <= 1'b0;
      band_loaded   <= 1'b0;
      loaded_band   <= '0;
    end else begin
      rom_rd_en <= (state_nxt == S_FETCH);
      if (state_nxt == S_FETCH) rom_addr <= {preset_sel, tap_nxt};
      if (state == S_WAIT) begin
        coeffs_out    <= rom_data;
        write_address <= tap;
      end
      write_enable <= (state_nxt == S_WRITE) ? (NUM_BANDS'(1) << cur_band) : '0;
      write_done   <= (state_nxt == S_DONE)  ? (NUM_BANDS'(1) << cur_band) : '0;
      busy         <= (state_nxt != S_IDLE);
      band_loaded  <= load_close;
      if (load_close) loaded_band <= cur_band;
    end
  end

endmodule

// File: doc/eq_coeff_scheduler.md
# eq_coeff_scheduler

Sequences coefficient reloads into the equalizer's 8 band filters. Host requests (band, preset) are queued in a per-band pending register and served round-robin. For each served band, 64 taps are fetched from the coefficient ROM and written through the band filter's write_enable / write_address / coeffs_in port, then the load is closed with write_done. The block sits between the host/preset logic and the 8 `filter` instances; it owns their coefficient write ports.

## Interface
- NUM_BANDS, 8: number of band filters served (band index width 3).
- TAPS, 64: coefficients per filter; write_address width 6.
- COEF_W, 16: coefficient width.
- PRESET_W, 4: preset index width; ROM address = {preset, tap}, 10 bits.
- clk  in  1  system clock; one clock.
- rst  in  1  reset; asynchronous, active-low.
- clk_enable  in  1  sample-rate enable shared with the filters; a filter write takes effect only in a cycle with clk_enable=1.
- req_valid  in  1  host request strobe, one clk.
- req_band  in  3  band to reload.
- req_preset  in  PRESET_W  preset to load into that band.
- rom_rd_en  out  1  ROM read strobe.
- rom_addr  out  10  {preset, tap}.
- rom_data  in  COEF_W  ROM data, valid exactly 1 clk after rom_rd_en.
- write_enable  out  NUM_BANDS  one-hot per-band write strobe.
- write_done  out  NUM_BANDS  one-hot per-band load-complete strobe.
- write_address  out  6  tap address, shared by all bands.
- coeffs_out  out  COEF_W  coefficient, shared by all bands.
- busy  out  1  high in any state other than IDLE.
- band_loaded  out  1  one-clk pulse when a band's write_done is accepted.
- loaded_band  out  3  band index qualifying band_loaded.

## Operation
- Pending store:
  - pending[7:0] plus preset_q[8][4].
  - req_valid sets pending[req_band] and overwrites preset_q[req_band]; a newer request for the same band replaces the older one (latest wins).
  - Requests are always accepted; there is no back-pressure.
- Request arriving for the band currently being loaded sets its pending bit again; that band is reloaded after the current load completes. The current load continues with its latched preset.
- Arbitration:
  - In IDLE, when pending != 0, the block selects the first set bit starting at rr_ptr, wrapping 7→0.
  - It latches cur_band and cur_preset, clears pending[cur_band], and sets rr_ptr = cur_band+1 mod 8.
  - If req_valid for cur_band occurs in the same clk as the clear, set wins.
- FSM states IDLE, FETCH, WAIT, WRITE, DONE:
  - IDLE → FETCH: on grant; tap=0.
  - FETCH: rom_rd_en=1, rom_addr={cur_preset,tap}; → WAIT.
  - WAIT: latch rom_data into coeffs_out; write_address=tap; → WRITE.
  - WRITE: write_enable[cur_band]=1, holding address and data.
    - On a clk with clk_enable=1: if tap==63 → DONE, else tap+1 → FETCH.
    - While clk_enable=0 it stays in WRITE.
  - DONE: write_enable=0, write_done[cur_band]=1. On a clk with clk_enable=1: band_loaded pulse, loaded_band=cur_band → IDLE.
- Only one bit of write_enable/write_done is ever high. write_enable and write_done are never high together.
- Tap counter is 6 bits. The 63→done transition uses an explicit compare, not wrap.
- Reset:
  - Asynchronous assertion; all state and outputs go to 0: pending=0, rr_ptr=0, FSM=IDLE, busy=0, all strobes 0, write_address=0, coeffs_out=0, rom_addr=0.
  - Reset mid-load abandons the load without issuing write_done, so the filter keeps its previous active coefficients. The host must re-request.

## Timing
- All outputs are registered.
- Grant: 1 clk after pending becomes nonzero in IDLE (IDLE→FETCH edge).
- Per tap: FETCH 1 + WAIT 1 + WRITE ≥1 clk. WRITE lasts until the first clk with clk_enable=1 (WRITE counted inclusive).
- With clk_enable tied 1:
  - 3 clks per tap and 1 DONE clk, so IDLE exit to IDLE re-entry = 193 clks.
  - Back-to-back bands: next FETCH is 1 clk after returning to IDLE.
- write_done is held until a clk_enable=1 cycle, so the filter input_register always samples it.
- A write_done pulse is followed by ≥1 cycle with write_enable=0 for that band.
- rom_data is sampled exactly 1 clk after rom_rd_en, independent of clk_enable.

## Test plan
- Single load, clk_enable=1: req band 2, preset 5 →
  - write_enable[2] high for 64 clks at 3-clk spacing, addresses 0..63, data = ROM[{5,k}].
  - write_done[2] high 1 clk, then band_loaded with loaded_band=2.
  - Total 193 clks busy.
- clk_enable 1-in-4: req band 0 → each WRITE holds until the enable cycle. Each tap is written exactly once, and write_done is held until an enable cycle.
- Round-robin: rr_ptr=0, simultaneous pending for bands 1, 6, 3 → service order 1, 3, 6. Then req 1 and 0 while serving 6 → order 0, 1.
- Latest wins / re-request:
  - Req band 4 preset 2 then preset 9 before grant → a single load with preset 9.
  - Req band 4 during its own load → a second load of band 4 follows.
- Reset mid-load: assert rst at tap 30 of band 7 →
  - All outputs 0 immediately, no write_done[7], pending cleared.
  - After release, the block idles until the next req.
- Same-clk set/clear: req_valid for band X in its grant clk → band X is reloaded again afterward.
